// File: rtl/stream_rx_pkg.sv
// Shared definitions for the stream receive core: version, register map,
// status bit positions and FSM state encoding.
package stream_rx_pkg;

  localparam logic [7:0] VERSION = 8'd1;

  // Register map
  localparam int ADDR_CTRL   = 0;  // write: soft reset, read: VERSION
  localparam int ADDR_LEN0   = 1;  // transfer length, bits 7:0
  localparam int ADDR_LEN1   = 2;  // transfer length, bits 15:8
  localparam int ADDR_LEN2   = 3;  // transfer length, bits 23:16 (write starts)
  localparam int ADDR_STATUS = 4;  // {5'b0, overflow, done, busy}
  localparam int ADDR_REM0   = 5;  // remaining words, bits 7:0
  localparam int ADDR_REM1   = 6;  // remaining words, bits 15:8
  localparam int ADDR_REM2   = 7;  // remaining words, bits 23:16

  // Status bit indices
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_OVERFLOW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Swap the two bytes of a 16-bit word
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/stream_rx_if.sv
// Register bus, host stream and consumer buffer signals of the stream
// receive core. The slave modport is the core's view, master is the
// environment's view.
interface stream_rx_if #(
  parameter int ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_WR;
  logic                 BUS_RD;
  logic                 STREAM_EMPTY_N;
  logic [15:0]          STREAM_DATA_IN;
  logic                 STREAM_READ_N;
  logic                 FIFO_READ_NEXT_IN;
  logic                 FIFO_EMPTY_OUT;
  logic [15:0]          FIFO_DATA_OUT;

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    input  STREAM_EMPTY_N, STREAM_DATA_IN, FIFO_READ_NEXT_IN,
    output BUS_DATA_OUT, STREAM_READ_N, FIFO_EMPTY_OUT, FIFO_DATA_OUT
  );

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    output STREAM_EMPTY_N, STREAM_DATA_IN, FIFO_READ_NEXT_IN,
    input  BUS_DATA_OUT, STREAM_READ_N, FIFO_EMPTY_OUT, FIFO_DATA_OUT
  );
endinterface

// File: rtl/stream_rx_buf.sv
// Single-clock show-ahead FIFO used as the receive buffer. Pointers carry
// one extra bit so full and empty are distinguishable; the head word reads
// as zero while the buffer is empty so stale storage never leaks out.
module stream_rx_buf #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr_r;
  ptr_t             rd_ptr_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                     (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty;
  assign dout      = empty ? '0 : mem[rd_ptr_r[DEPTH_LOG2-1:0]];

  // Storage write; contents need no reset because the output is masked when empty
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem[wr_ptr_r[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // Read/write pointer advance with hard and soft clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

endmodule

// File: rtl/stream_rx_core.sv
// Stream receive core: pulls a programmed number of 16-bit words from a host
// stream FIFO (one-cycle read latency) into a local show-ahead buffer, with a
// small byte-wide register interface for length, status and soft reset.
// Optional feature: define STREAM_RX_BYTESWAP_EN to store each captured word
// with its bytes swapped.
import stream_rx_pkg::*;

module stream_rx_core #(
  parameter int ABUSWIDTH  = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST,
  stream_rx_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t              state_r;
  state_t              state_next_s;
  logic [23:0]         length_r;
  logic [23:0]         remaining_r;
  logic                start_r;
  logic                overflow_r;
  logic                read_pend_r;
  logic [7:0]          bus_data_out_r;
  logic [7:0]          rd_mux_s;
  logic [7:0]          status_s;
  logic                soft_rst_s;
  logic                start_wr_s;
  logic                read_req_s;
  logic                capture_s;
  logic [15:0]         cap_word_s;
  logic                buf_empty_s;
  logic [DEPTH_LOG2:0] occ_s;

  assign soft_rst_s = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(ADDR_CTRL));
  assign start_wr_s = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(ADDR_LEN2));
  // A word requested in the previous cycle arrives now, regardless of EMPTY_N
  assign capture_s  = read_pend_r;

`ifdef STREAM_RX_BYTESWAP_EN
  assign cap_word_s = byte_swap(bus.STREAM_DATA_IN);
`else
  assign cap_word_s = bus.STREAM_DATA_IN;
`endif

  stream_rx_buf #(
    .WIDTH      (16),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_buf (
    .clk   (BUS_CLK),
    .rst   (BUS_RST),
    .srst  (soft_rst_s),
    .push  (capture_s),
    .din   (cap_word_s),
    .pop   (bus.FIFO_READ_NEXT_IN),
    .dout  (bus.FIFO_DATA_OUT),
    .empty (buf_empty_s),
    .count (occ_s)
  );

  assign bus.FIFO_EMPTY_OUT = buf_empty_s;
  assign bus.STREAM_READ_N  = ~read_req_s;
  assign bus.BUS_DATA_OUT   = bus_data_out_r;

  // Issue a host read only when the word is still owed and will fit in the buffer
  always_comb begin
    read_req_s = 1'b0;
    if ((state_r == BUSY) && bus.STREAM_EMPTY_N && !soft_rst_s &&
        (remaining_r > 24'(read_pend_r)) &&
        ((int'(occ_s) + int'(read_pend_r)) < DEPTH)) begin
      read_req_s = 1'b1;
    end else begin
      read_req_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_r <= IDLE;
    end else if (soft_rst_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: starts come from the registered start pulse
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_r) state_next_s = (length_r != 24'd0) ? BUSY : DONE;
        else         state_next_s = IDLE;
      end
      BUSY: begin
        if (remaining_r == 24'd0) state_next_s = DONE;
        else                      state_next_s = BUSY;
      end
      DONE: begin
        if (start_r) state_next_s = (length_r != 24'd0) ? BUSY : DONE;
        else         state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Length register bytes; writable in any state
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      length_r <= 24'd0;
    end else if (soft_rst_s) begin
      length_r <= 24'd0;
    end else if (bus.BUS_WR) begin
      if (bus.BUS_ADD == ABUSWIDTH'(ADDR_LEN0))      length_r[7:0]   <= bus.BUS_DATA_IN;
      else if (bus.BUS_ADD == ABUSWIDTH'(ADDR_LEN1)) length_r[15:8]  <= bus.BUS_DATA_IN;
      else if (bus.BUS_ADD == ABUSWIDTH'(ADDR_LEN2)) length_r[23:16] <= bus.BUS_DATA_IN;
    end
  end

  // Start pulse, in-flight tracking, remaining count and sticky misuse flag
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      start_r     <= 1'b0;
      read_pend_r <= 1'b0;
      remaining_r <= 24'd0;
      overflow_r  <= 1'b0;
    end else if (soft_rst_s) begin
      start_r     <= 1'b0;
      read_pend_r <= 1'b0;
      remaining_r <= 24'd0;
      overflow_r  <= 1'b0;
    end else begin
      start_r     <= start_wr_s && (state_r != BUSY);
      read_pend_r <= read_req_s;
      if (start_r) begin
        remaining_r <= length_r;
      end else if (capture_s && (remaining_r != 24'd0)) begin
        remaining_r <= remaining_r - 24'd1;
      end
      if (start_r) begin
        overflow_r <= 1'b0;
      end else if (bus.FIFO_READ_NEXT_IN && buf_empty_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Status byte assembly
  always_comb begin
    status_s                = 8'h00;
    status_s[STAT_BUSY]     = (state_r == BUSY);
    status_s[STAT_DONE]     = (state_r == DONE);
    status_s[STAT_OVERFLOW] = overflow_r;
  end

  // Register read multiplexer
  always_comb begin
    rd_mux_s = 8'h00;
    case (bus.BUS_ADD)
      ABUSWIDTH'(ADDR_CTRL):   rd_mux_s = VERSION;
      ABUSWIDTH'(ADDR_LEN0):   rd_mux_s = length_r[7:0];
      ABUSWIDTH'(ADDR_LEN1):   rd_mux_s = length_r[15:8];
      ABUSWIDTH'(ADDR_LEN2):   rd_mux_s = length_r[23:16];
      ABUSWIDTH'(ADDR_STATUS): rd_mux_s = status_s;
      ABUSWIDTH'(ADDR_REM0):   rd_mux_s = remaining_r[7:0];
      ABUSWIDTH'(ADDR_REM1):   rd_mux_s = remaining_r[15:8];
      ABUSWIDTH'(ADDR_REM2):   rd_mux_s = remaining_r[23:16];
      default:                 rd_mux_s = 8'h00;
    endcase
  end

  // Registered read data, updated only on a read strobe
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      bus_data_out_r <= 8'h00;
    end else if (soft_rst_s) begin
      bus_data_out_r <= 8'h00;
    end else if (bus.BUS_RD) begin
      bus_data_out_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_stream_rx_core.sv
// Scoreboard bench for stream_rx_core: a host FIFO model answers reads with
// one-cycle latency, expected buffer words are queued when host words are
// loaded, and a monitor pops/compares whenever the buffer shows a word.
// Honors STREAM_RX_BYTESWAP_EN for the expected word format.
module tb_stream_rx_core;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_rx_if #(.ABUSWIDTH(16)) bus_if ();

  stream_rx_core #(.ABUSWIDTH(16), .DEPTH_LOG2(4)) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] host_q[$];
  logic [15:0] exp_q[$];
  int reads_issued = 0;
  int rx_cnt = 0;
  bit pop_en = 1'b0;
  bit force_pop = 1'b0;
  bit toggle_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef STREAM_RX_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // Host stream FIFO: a read seen low in cycle N delivers its word in cycle N+1
  initial begin : host
    bit rd;
    bit phase;
    phase = 1'b0;
    bus_if.STREAM_EMPTY_N = 1'b0;
    bus_if.STREAM_DATA_IN = 16'h0000;
    forever begin
      @(negedge clk);
      #4;
      rd = (bus_if.STREAM_READ_N === 1'b0);
      @(posedge clk);
      #1;
      if (rd) begin
        reads_issued++;
        if (host_q.size() > 0) bus_if.STREAM_DATA_IN = host_q.pop_front();
        else                   bus_if.STREAM_DATA_IN = 16'hDEAD;
      end
      phase = ~phase;
      bus_if.STREAM_EMPTY_N = (host_q.size() > 0) && (!toggle_en || phase);
    end
  end

  // Consumer monitor: compares the head word with the scoreboard and pops it
  initial begin : monitor
    bus_if.FIFO_READ_NEXT_IN = 1'b0;
    forever begin
      @(negedge clk);
      if (force_pop) begin
        bus_if.FIFO_READ_NEXT_IN = 1'b1;
        force_pop = 1'b0;
      end else if (pop_en && bus_if.FIFO_EMPTY_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_extra_word actual=0x%0h expected=none", bus_if.FIFO_DATA_OUT);
        end else begin
          check("rx_word", bus_if.FIFO_DATA_OUT, exp_q.pop_front());
        end
        rx_cnt++;
        bus_if.FIFO_READ_NEXT_IN = 1'b1;
      end else begin
        bus_if.FIFO_READ_NEXT_IN = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.BUS_ADD = a; bus_if.BUS_DATA_IN = d; bus_if.BUS_WR = 1'b1;
    @(negedge clk);
    bus_if.BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.BUS_ADD = a; bus_if.BUS_RD = 1'b1;
    @(negedge clk);
    bus_if.BUS_RD = 1'b0;
    d = bus_if.BUS_DATA_OUT;
  endtask

  task automatic start_xfer(input logic [23:0] len);
    bus_write(16'd1, len[7:0]);
    bus_write(16'd2, len[15:8]);
    bus_write(16'd3, len[23:16]);
  endtask

  task automatic load_host(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      host_q.push_back(base + 16'(i));
      exp_q.push_back(model_word(base + 16'(i)));
    end
  endtask

  task automatic wait_status(input logic [7:0] want, input int budget, input string name);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      bus_read(16'd4, s);
      n++;
    end while (s !== want && n < budget);
    check(name, s, want);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] rd8;
    int base_reads;
    int base_rx;
    int n;
    rst = 1'b1;
    bus_if.BUS_ADD = 16'd0; bus_if.BUS_DATA_IN = 8'h00;
    bus_if.BUS_WR = 1'b0; bus_if.BUS_RD = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read_n", bus_if.STREAM_READ_N, 1'b1);
    check("rst_empty", bus_if.FIFO_EMPTY_OUT, 1'b1);
    check("rst_fifo_data", bus_if.FIFO_DATA_OUT, 16'h0000);
    check("rst_bus_data", bus_if.BUS_DATA_OUT, 8'h00);
    rst = 1'b0;
    bus_read(16'd4, rd8); check("status_after_rst", rd8, 8'h00);
    bus_read(16'd0, rd8); check("version", rd8, 8'h01);
    bus_read(16'd9, rd8); check("unmapped_addr", rd8, 8'h00);
    bus_read(16'd0, rd8);
    @(negedge clk); bus_if.BUS_ADD = 16'd4;
    repeat (2) @(negedge clk);
    check("rd_data_hold", bus_if.BUS_DATA_OUT, 8'h01);

    // Length 8, consumer always pops
    pop_en = 1'b1; base_reads = reads_issued; base_rx = rx_cnt;
    load_host(16'h0001, 8);
    start_xfer(24'd8);
    wait_status(8'h02, 100, "t1_status_done");
    wait_drain(50, "t1_drain");
    check("t1_words", rx_cnt - base_rx, 8);
    check("t1_reads", reads_issued - base_reads, 8);
    bus_read(16'd5, rd8); check("t1_remaining", rd8, 8'h00);
    check("t1_read_n_idle", bus_if.STREAM_READ_N, 1'b1);

    // Length 40 with stalled consumer: reads stop at buffer depth
    pop_en = 1'b0; base_reads = reads_issued; base_rx = rx_cnt;
    load_host(16'h0100, 40);
    start_xfer(24'd40);
    repeat (60) @(negedge clk);
    check("t2_reads_stalled", reads_issued - base_reads, 16);
    check("t2_read_n_held", bus_if.STREAM_READ_N, 1'b1);
    bus_read(16'd5, rd8); check("t2_remaining", rd8, 8'd24);
    bus_read(16'd4, rd8); check("t2_status_busy", rd8, 8'h01);
    pop_en = 1'b1;
    wait_status(8'h02, 200, "t2_status_done");
    wait_drain(50, "t2_drain");
    check("t2_words", rx_cnt - base_rx, 40);
    check("t2_reads", reads_issued - base_reads, 40);

    // Length 10 with EMPTY_N toggling every cycle
    toggle_en = 1'b1; base_reads = reads_issued; base_rx = rx_cnt;
    load_host(16'h0200, 10);
    start_xfer(24'd10);
    wait_status(8'h02, 200, "t3_status_done");
    wait_drain(50, "t3_drain");
    check("t3_words", rx_cnt - base_rx, 10);
    check("t3_reads", reads_issued - base_reads, 10);
    toggle_en = 1'b0;

    // Soft reset mid-transfer with remaining = 5
    pop_en = 1'b0; base_reads = reads_issued;
    load_host(16'h0300, 21);
    start_xfer(24'd21);
    repeat (60) @(negedge clk);
    check("t4_reads_stalled", reads_issued - base_reads, 16);
    bus_read(16'd5, rd8); check("t4_remaining_pre", rd8, 8'd5);
    bus_write(16'd0, 8'h00);
    check("t4_srst_empty", bus_if.FIFO_EMPTY_OUT, 1'b1);
    check("t4_srst_fifo_data", bus_if.FIFO_DATA_OUT, 16'h0000);
    check("t4_srst_read_n", bus_if.STREAM_READ_N, 1'b1);
    exp_q.delete();
    host_q.push_back(16'hBEEF);
    base_reads = reads_issued;
    repeat (20) @(negedge clk);
    check("t4_no_reads", reads_issued - base_reads, 0);
    host_q.delete();
    bus_read(16'd4, rd8); check("t4_status", rd8, 8'h00);
    bus_read(16'd5, rd8); check("t4_remaining", rd8, 8'h00);
    bus_read(16'd1, rd8); check("t4_length", rd8, 8'h00);

    // Pop on empty buffer, then zero-length start
    base_reads = reads_issued;
    @(posedge clk); #1; force_pop = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(16'd4, rd8); check("t5_overflow", rd8, 8'h04);
    start_xfer(24'd0);
    bus_read(16'd4, rd8); check("t5_zero_len_done", rd8, 8'h02);
    repeat (5) @(negedge clk);
    check("t5_no_reads", reads_issued - base_reads, 0);
    check("t5_empty", bus_if.FIFO_EMPTY_OUT, 1'b1);

    // Byte order of a captured word
    pop_en = 1'b0;
    host_q.push_back(16'h12AB);
`ifdef STREAM_RX_BYTESWAP_EN
    exp_q.push_back(16'hAB12);
`else
    exp_q.push_back(16'h12AB);
`endif
    start_xfer(24'd1);
    n = 0;
    while (bus_if.FIFO_EMPTY_OUT !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_captured", bus_if.FIFO_EMPTY_OUT, 1'b0);
`ifdef STREAM_RX_BYTESWAP_EN
    check("t6_head_word", bus_if.FIFO_DATA_OUT, 16'hAB12);
`else
    check("t6_head_word", bus_if.FIFO_DATA_OUT, 16'h12AB);
`endif
    pop_en = 1'b1;
    wait_status(8'h02, 50, "t6_status_done");
    wait_drain(20, "t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rx_core.md
STREAM_RX_CORE -- requirements
Module: stream_rx_core

Interface
REQ-001 Parameter ABUSWIDTH, default 16, bus address width.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of receive buffer depth in 16-bit words.
REQ-003 BUS_CLK  in  1  single clock; all logic on its rising edge.
REQ-004 BUS_RST  in  1  reset, asynchronous, active-high.
REQ-005 BUS_ADD  in  ABUSWIDTH  register address.
REQ-006 BUS_DATA_IN  in  8  register write data.
REQ-007 BUS_DATA_OUT  out  8  register read data, registered.
REQ-008 BUS_WR, BUS_RD  in  1 each  register write and read strobes.
REQ-009 STREAM_EMPTY_N  in  1  host stream FIFO holds at least one word.
REQ-010 STREAM_DATA_IN  in  16  host stream word.
REQ-011 STREAM_READ_N  out  1  active-low read request to the host stream FIFO.
REQ-012 FIFO_READ_NEXT_IN  in  1  consumer pops one buffered word.
REQ-013 FIFO_EMPTY_OUT  out  1  receive buffer empty.
REQ-014 FIFO_DATA_OUT  out  16  head word of receive buffer (show-ahead).

Function
REQ-015 Register map: 0 write = soft reset, read = VERSION (1); 1..3 = 24-bit transfer length in words, LSB first; 4 = status {5'b0, overflow, done, busy}; 5..7 = remaining word count, LSB first; other addresses read 0.
REQ-016 BUS_DATA_OUT SHALL update one cycle after BUS_RD and hold otherwise.
REQ-017 A write to address 3 while IDLE SHALL start a transfer one cycle later; while BUSY the start SHALL be ignored (the length registers still update).
REQ-018 FSM states: IDLE, BUSY, DONE; IDLE->BUSY on start with length!=0; IDLE->DONE on start with length==0; BUSY->DONE when remaining reaches 0; DONE->BUSY on a new start; any state->IDLE on soft reset.
REQ-019 STREAM_READ_N SHALL be low in cycle N only if BUSY, STREAM_EMPTY_N=1, remaining minus in-flight reads > 0, and buffer occupancy plus in-flight reads < 2**DEPTH_LOG2.
REQ-020 Read latency is one cycle: STREAM_DATA_IN SHALL be captured into the buffer at cycle N+1 for every cycle N with STREAM_READ_N low; remaining SHALL decrement by one per captured word.
REQ-021 STREAM_EMPTY_N deasserting while a read is in flight SHALL NOT cancel the capture of that word.
REQ-022 Simultaneous capture and FIFO_READ_NEXT_IN SHALL leave occupancy unchanged; capture into an empty buffer SHALL make FIFO_EMPTY_OUT low the next cycle.
REQ-023 FIFO_READ_NEXT_IN while FIFO_EMPTY_OUT=1 SHALL be ignored and SHALL set the sticky overflow (misuse) flag.
REQ-024 Buffer pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1); the MSB distinguishes full from empty.
REQ-025 Overflow and done SHALL be cleared by a start or a reset.

Reset
REQ-026 BUS_RST (asynchronous) and soft reset (synchronous, one cycle after the address-0 write) SHALL both clear: FSM to IDLE, buffer empty, counts and length to 0, flags to 0, STREAM_READ_N=1, FIFO_EMPTY_OUT=1, FIFO_DATA_OUT=0, BUS_DATA_OUT=0.
REQ-027 A reset during an in-flight read SHALL discard that word.

Configuration
REQ-028 With STREAM_RX_BYTESWAP_EN defined, captured words SHALL be stored as {STREAM_DATA_IN[7:0], STREAM_DATA_IN[15:8]}; without it, words SHALL be stored unmodified.

Structure
REQ-029 Package stream_rx_pkg SHALL hold VERSION, register address constants, the status bit indices and the FSM state type.
REQ-030 The receive buffer SHALL be the sub-module stream_rx_buf (single-clock show-ahead FIFO, width 16, depth 2**DEPTH_LOG2).

Verification
REQ-031 Length 8, host supplies 0x0001..0x0008 continuously, consumer always pops -> 8 words in order, done=1, busy=0, remaining=0, STREAM_READ_N high afterwards.
REQ-032 Length 40, DEPTH_LOG2=4, consumer stalled -> exactly 16 reads issued, then STREAM_READ_N held high; after draining, all 40 words arrive with no loss or duplication.
REQ-033 STREAM_EMPTY_N toggles every cycle during a length-10 transfer -> 10 words captured, including words whose read cycle preceded an EMPTY_N drop.
REQ-034 Address-0 write at mid-transfer (remaining=5) -> next cycle FIFO_EMPTY_OUT=1, status=0x00, remaining=0, no further reads.
REQ-035 Pop on empty buffer -> status bit2 set; a new start with length 0 -> status=0x02 immediately, no reads.
REQ-036 With STREAM_RX_BYTESWAP_EN, host word 0x12AB -> FIFO_DATA_OUT=0xAB12; without it -> 0x12AB.
